// File: rtl/integrate_dump_pkg.sv
// Shared definitions for the track channel: default widths, code-rate NCO step
// and the bit layout of wiped-off baseband samples.
package integrate_dump_pkg;
  localparam int ACC_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 15;

  // Nominal C/A chipping-rate NCO increment: 1.023 MHz / 16.8 MHz * 2^32.
  localparam logic [31:0] CA_RATE_INC = 32'd261532830;

  // Sample layout: [SIGN_BIT] = sign (1 = negative), [MAG_W-1:0] = magnitude.
  localparam int SAMPLE_W = 3;
  localparam int SIGN_BIT = 2;
  localparam int MAG_W    = 2;
endpackage

// File: rtl/integrate_dump_sample_decode.sv
// Sign/magnitude baseband sample to two's complement; shared by correlator arms.
module sample_decode
  import integrate_dump_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic        [SAMPLE_W-1:0]  sample,
  output logic signed [ACC_WIDTH-1:0] value
);
  logic signed [ACC_WIDTH-1:0] mag;

  assign mag   = {{(ACC_WIDTH-MAG_W){1'b0}}, sample[MAG_W-1:0]};
  // A negative zero negates to zero, so no special case is needed.
  assign value = sample[SIGN_BIT] ? -mag : mag;
endmodule

// File: rtl/integrate_dump.sv
// Integrate-and-dump correlator back end with valid/ready result handoff and
// sticky overrun. Define INTDUMP_SATURATE_EN to clamp the accumulator instead of wrapping.
module integrate_dump
  import integrate_dump_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        sample_valid,
  input  logic        [SAMPLE_W-1:0]  sample,
  input  logic                        dump,
  output logic signed [ACC_WIDTH-1:0] result,
  output logic        [CNT_WIDTH-1:0] result_count,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
`ifdef INTDUMP_SATURATE_EN
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      acc_add = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      acc_add = s[ACC_WIDTH-1:0];
`else
    acc_add = a + b;
`endif
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 inc
  );
    cnt_inc = (inc && (c != {CNT_WIDTH{1'b1}})) ? c + 1'b1 : c;
  endfunction

  logic signed [ACC_WIDTH-1:0] value;
  logic signed [ACC_WIDTH-1:0] in_val;
  logic signed [ACC_WIDTH-1:0] acc_p0;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic        [CNT_WIDTH-1:0] cnt_p0;
  logic        [CNT_WIDTH-1:0] cnt_nxt;
  logic                        take;
  logic                        do_dump;
  logic                        ovr_set;

  sample_decode #(.ACC_WIDTH(ACC_WIDTH)) u_decode (
    .sample (sample),
    .value  (value)
  );

  assign take    = enable & sample_valid;
  assign do_dump = enable & dump;
  assign in_val  = take ? value : '0;
  assign acc_nxt = acc_add(acc_p0, in_val);
  assign cnt_nxt = cnt_inc(cnt_p0, take);
  assign ovr_set = do_dump & result_valid & ~result_ready;

  // Stage p0: running integration, cleared on each epoch dump
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (do_dump) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (enable) begin
      acc_p0 <= acc_nxt;
      cnt_p0 <= cnt_nxt;
    end
  end

  // Stage p1: result register and handshake, one clock after the dump
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      result_count <= '0;
      result_valid <= 1'b0;
    end else if (do_dump) begin
      result       <= acc_nxt;
      result_count <= cnt_nxt;
      result_valid <= 1'b1;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overrun <= 1'b0;
    else if (ovr_set)
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end

endmodule
